// File: rtl/gauss_row_feeder.sv
// Top-edge feeder for the Gaussian-elimination systolic array: accepts whole rows,
// emits them diagonally skewed per column, then flushes with finish-flagged zero rows.
module gauss_row_feeder #(
  parameter int unsigned GF_BIT      = 4,
  parameter int unsigned OP_CODE_LEN = 4,
  parameter int unsigned NUM_COLS    = 3,
  parameter int unsigned NUM_ROWS    = 4,
  parameter int unsigned FLUSH_LEN   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            go,
  input  logic [OP_CODE_LEN-1:0]          op_cmd,
  input  logic [NUM_COLS*GF_BIT-1:0]      row_data,
  input  logic                            row_valid,
  output logic                            row_ready,
  output logic [NUM_COLS*GF_BIT-1:0]      lane_data,
  output logic [NUM_COLS*OP_CODE_LEN-1:0] lane_op,
  output logic [NUM_COLS-1:0]             lane_start,
  output logic [NUM_COLS-1:0]             lane_finish,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned ROW_W   = NUM_COLS * GF_BIT;
  localparam int unsigned ROW_CW  = $clog2(NUM_ROWS + 1);
  localparam int unsigned FLUSH_CW = $clog2(FLUSH_LEN + 1);
  localparam int unsigned DRAIN_CW = $clog2(NUM_COLS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FEED, ST_FLUSH, ST_DRAIN, ST_DONE
  } state_t;

  typedef struct packed {
    logic [OP_CODE_LEN-1:0] op;
    logic                   start;
    logic                   finish;
  } ctl_t;

  typedef struct packed {
    logic [GF_BIT-1:0]      data;
    logic [OP_CODE_LEN-1:0] op;
    logic                   start;
    logic                   finish;
  } lane_t;

  state_t                 state_q, state_d;
  logic [ROW_CW-1:0]      row_cnt_q, row_cnt_d;
  logic [FLUSH_CW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [DRAIN_CW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [OP_CODE_LEN-1:0] op_q, op_d;
  logic [ROW_W-1:0]       s0_row_q, s0_row_d;
  ctl_t                   s0_ctl_q, s0_ctl_d;
  logic                   row_ready_d, busy_d, done_d;

  // State, counters, stage 0 and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      op_q        <= '0;
      s0_row_q    <= '0;
      s0_ctl_q    <= '0;
      row_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      op_q        <= op_d;
      s0_row_q    <= s0_row_d;
      s0_ctl_q    <= s0_ctl_d;
      row_ready   <= row_ready_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next state and stage-0 entry; anything outside FEED/FLUSH loads a NOP
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    op_d        = op_q;
    s0_row_d    = '0;
    s0_ctl_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          op_d      = op_cmd;
          row_cnt_d = '0;
          state_d   = ST_FEED;
        end
      end
      ST_FEED: begin
        if (row_valid) begin
          s0_row_d       = row_data;
          s0_ctl_d.op    = op_q;
          s0_ctl_d.start = (row_cnt_q == '0);
          row_cnt_d      = row_cnt_q + ROW_CW'(1);
          if (row_cnt_q == ROW_CW'(NUM_ROWS - 1)) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        s0_ctl_d.op     = op_q;
        s0_ctl_d.finish = 1'b1;
        flush_cnt_d     = flush_cnt_q + FLUSH_CW'(1);
        if (flush_cnt_q == FLUSH_CW'(FLUSH_LEN - 1)) begin
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRAIN_CW'(1);
        if (drain_cnt_q == DRAIN_CW'(NUM_COLS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    row_ready_d = (state_d == ST_FEED);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // Lane j delays its slice of stage 0 by j extra registers
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_lane
    lane_t tap;
    lane_t out;
    assign tap = {s0_row_q[j*GF_BIT +: GF_BIT], s0_ctl_q};

    if (j == 0) begin : g_direct
      assign out = tap;
    end else begin : g_skew
      lane_t sr [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else begin
          sr[0] <= tap;
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign out = sr[j-1];
    end

    assign lane_data[j*GF_BIT +: GF_BIT]           = out.data;
    assign lane_op[j*OP_CODE_LEN +: OP_CODE_LEN]   = out.op;
    assign lane_start[j]                           = out.start;
    assign lane_finish[j]                          = out.finish;
  end

endmodule

// File: tb/tb_gauss_row_feeder.sv
// Bench for gauss_row_feeder: per-job timeline model of stage-0 entries, lanes read it skewed.
module tb_gauss_row_feeder;
  localparam int GF   = 4;
  localparam int OPW  = 4;
  localparam int NC   = 3;
  localparam int NR   = 2;
  localparam int FL   = 3;
  localparam int DW   = NC * GF;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            go = 1'b0;
  logic [OPW-1:0]  op_cmd = '0;
  logic [DW-1:0]   row_data = '0;
  logic            row_valid = 1'b0;
  logic            row_ready;
  logic [DW-1:0]   lane_data;
  logic [NC*OPW-1:0] lane_op;
  logic [NC-1:0]   lane_start, lane_finish;
  logic            busy, done;

  gauss_row_feeder #(.GF_BIT(GF), .OP_CODE_LEN(OPW), .NUM_COLS(NC), .NUM_ROWS(NR), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op_cmd(op_cmd), .row_data(row_data),
    .row_valid(row_valid), .row_ready(row_ready), .lane_data(lane_data), .lane_op(lane_op),
    .lane_start(lane_start), .lane_finish(lane_finish), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: stage-0 entry loaded at each edge index, plus per-sample status
  bit [DW-1:0]  m_row [MAXC];
  bit [OPW-1:0] m_op  [MAXC];
  bit           m_st  [MAXC];
  bit           m_fin [MAXC];
  bit           m_busy[MAXC];
  bit           m_rdy [MAXC];
  bit           m_done[MAXC];

  logic [DW-1:0]     cap_data [MAXC];
  logic [NC*OPW-1:0] cap_op   [MAXC];
  logic [NC-1:0]     cap_st   [MAXC];
  logic [NC-1:0]     cap_fin  [MAXC];
  logic              cap_done [MAXC];
  logic              cap_busy [MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      m_row[i] = '0; m_op[i] = '0; m_st[i] = 1'b0; m_fin[i] = 1'b0;
      m_busy[i] = 1'b0; m_rdy[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  logic [DW-1:0]     e_d;
  logic [NC*OPW-1:0] e_o;
  logic [NC-1:0]     e_s, e_f;

  always @(negedge clk) begin
    cap_data[cyc] = lane_data; cap_op[cyc] = lane_op; cap_st[cyc] = lane_start;
    cap_fin[cyc] = lane_finish; cap_done[cyc] = done; cap_busy[cyc] = busy;
    if (chk_en) begin
      for (int j = 0; j < NC; j++) begin
        int idx;
        idx = cyc - j;
        if (idx >= 0) begin
          e_d[j*GF +: GF] = m_row[idx][j*GF +: GF];
          e_o[j*OPW +: OPW] = m_op[idx];
          e_s[j] = m_st[idx];
          e_f[j] = m_fin[idx];
        end else begin
          e_d[j*GF +: GF] = '0; e_o[j*OPW +: OPW] = '0; e_s[j] = 1'b0; e_f[j] = 1'b0;
        end
      end
      chk("lane_data", 64'(lane_data), 64'(e_d));
      chk("lane_op", 64'(lane_op), 64'(e_o));
      chk("lane_start", 64'(lane_start), 64'(e_s));
      chk("lane_finish", 64'(lane_finish), 64'(e_f));
      chk("row_ready", 64'(row_ready), 64'(m_rdy[cyc]));
      chk("busy", 64'(busy), 64'(m_busy[cyc]));
      chk("done", 64'(done), 64'(m_done[cyc]));
    end
  end

  // Plans the whole job into the model, then drives it; returns the go edge index
  task automatic run_job(input logic [OPW-1:0] op, input bit rnd, input int bub,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, output int g);
    bit vq[$];
    logic [DW-1:0] dq[$];
    int f, r, nb, kd, idx;
    if (rnd) repeat ($urandom_range(0, 1)) begin vq.push_back(1'b0); dq.push_back('0); end
    for (int k = 0; k < NR; k++) begin
      if (k > 0) begin
        nb = rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : bub;
        repeat (nb) begin vq.push_back(1'b0); dq.push_back('0); end
      end
      vq.push_back(1'b1);
      dq.push_back(rnd ? DW'($urandom) : ((k == 0) ? d0 : d1));
    end
    g = cyc + 1;
    f = vq.size();
    kd = f + FL + NC;
    r = 0;
    for (int i = 0; i < f; i++) begin
      idx = g + 1 + i;
      m_fin[idx] = 1'b0;
      if (vq[i]) begin
        m_row[idx] = dq[i]; m_op[idx] = op; m_st[idx] = (r == 0); r++;
      end else begin
        m_row[idx] = '0; m_op[idx] = '0; m_st[idx] = 1'b0;
      end
    end
    for (int k = 1; k <= FL; k++) begin
      idx = g + f + k;
      m_row[idx] = '0; m_op[idx] = op; m_st[idx] = 1'b0; m_fin[idx] = 1'b1;
    end
    for (int s = g; s <= g + kd; s++) begin
      m_busy[s] = 1'b1;
      m_rdy[s] = (s < g + f);
    end
    m_done[g + kd] = 1'b1;

    go = 1'b1; op_cmd = op; row_valid = 1'($urandom); row_data = DW'($urandom);
    for (int i = 0; i < f; i++) begin
      @(posedge clk); #1;
      go = rnd ? 1'($urandom) : (i == 1);
      op_cmd = rnd ? OPW'($urandom) : OPW'(4);
      row_valid = vq[i];
      row_data = vq[i] ? dq[i] : DW'($urandom);
    end
    repeat (FL + NC + 1) begin
      @(posedge clk); #1;
      go = rnd ? 1'($urandom) : 1'b0;
      row_valid = rnd ? 1'($urandom) : 1'b1;
      row_data = DW'($urandom);
    end
    @(posedge clk); #1;
    go = 1'b0; row_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  int g1, g2, g3, gr;

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lane_data", 64'(lane_data), 64'h0);
    chk("reset_lane_op", 64'(lane_op), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_ready", 64'(row_ready), 64'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Basic skew, flush and done timing
    run_job(4'h1, 1'b0, 0, 12'h321, 12'h654, g1);
    chk("lit_d1", 64'(cap_data[g1+1]), 64'h001);
    chk("lit_d2", 64'(cap_data[g1+2]), 64'h024);
    chk("lit_d3", 64'(cap_data[g1+3]), 64'h350);
    chk("lit_s1", 64'(cap_st[g1+1]), 64'b001);
    chk("lit_s2", 64'(cap_st[g1+2]), 64'b010);
    chk("lit_s3", 64'(cap_st[g1+3]), 64'b100);
    chk("lit_f3", 64'(cap_fin[g1+3]), 64'b001);
    chk("lit_op3", 64'(cap_op[g1+3]), 64'h111);
    chk("lit_done7", 64'(cap_done[g1+7]), 64'h0);
    chk("lit_done8", 64'(cap_done[g1+8]), 64'h1);
    chk("lit_busy9", 64'(cap_busy[g1+9]), 64'h0);

    // Back-to-back with two bubbles between the rows
    run_job(4'h1, 1'b0, 2, 12'h321, 12'h654, g2);
    chk("lit_b2b_start", 64'(cap_st[g2+1]), 64'b001);
    chk("lit_b2b_fin", 64'(cap_fin[g2+1]), 64'b000);
    chk("lit_bub_d", 64'(cap_data[g2+2][3:0]), 64'h0);
    chk("lit_bub_op", 64'(cap_op[g2+2][3:0]), 64'h0);
    chk("lit_bub_row1", 64'(cap_data[g2+4][3:0]), 64'h4);
    chk("lit_bub_st", 64'(cap_st[g2+4]), 64'b000);
    chk("lit_bub_done8", 64'(cap_done[g2+8]), 64'h0);
    chk("lit_bub_done10", 64'(cap_done[g2+10]), 64'h1);

    // Asynchronous reset in the middle of the flush
    chk_en = 1'b0;
    gr = cyc + 1;
    go = 1'b1; op_cmd = 4'h1; row_valid = 1'b1; row_data = DW'($urandom);
    @(posedge clk); #1; go = 1'b0; row_data = DW'($urandom);
    @(posedge clk); #1; row_data = DW'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy), 64'h1);
    chk("pre_rst_fin0", 64'(lane_finish[0]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_lane_data", 64'(lane_data), 64'h0);
    chk("rst_lane_op", 64'(lane_op), 64'h0);
    chk("rst_lane_start", 64'(lane_start), 64'h0);
    chk("rst_lane_finish", 64'(lane_finish), 64'h0);
    chk("rst_ready", 64'(row_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    row_valid = 1'b0;
    clear_model();
    chk_en = 1'b1;

    run_job(4'h1, 1'b0, 0, 12'hABC, 12'h987, g3);
    chk("lit_post_rst_d", 64'(cap_data[g3+1]), 64'h00C);
    chk("lit_post_rst_done", 64'(cap_done[g3+8]), 64'h1);

    // Randomized jobs with random gaps, ignored inputs and bubbles
    for (int n = 0; n < 30; n++) begin
      int gx;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        row_valid = 1'($urandom); row_data = DW'($urandom); op_cmd = OPW'($urandom);
      end
      row_valid = 1'b0;
      run_job(OPW'($urandom), 1'b1, 0, '0, '0, gx);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
